// File: rtl/cic_interpolator_if.sv
// Streaming port bundle for cic_interpolator: ready/valid sample input,
// output-advance enable, registered output and underflow flag.
interface cic_interpolator_if #(
  parameter int INPUT_WIDTH  = 32,
  parameter int OUTPUT_WIDTH = 32
);
  logic signed [INPUT_WIDTH-1:0]  data_in;
  logic                           data_valid;
  logic                           data_ready;
  logic                           out_ready;
  logic signed [OUTPUT_WIDTH-1:0] data_out;
  logic                           output_valid;
  logic                           underflow;

  modport master (
    output data_in, data_valid, out_ready,
    input  data_ready, data_out, output_valid, underflow
  );

  modport slave (
    input  data_in, data_valid, out_ready,
    output data_ready, data_out, output_valid, underflow
  );
endinterface

// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator: combs at input rate, zero-stuff by R, integrators at output rate.
// Optional macro CIC_INTERP_ROUND_EN: round half up before the gain-normalising shift.
module cic_interpolator #(
  parameter int INPUT_WIDTH   = 32,
  parameter int OUTPUT_WIDTH  = 32,
  parameter int STAGES        = 3,
  parameter int INTERPOLATION = 8,
  parameter int DIFF_DELAY    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  cic_interpolator_if.slave   bus
);
  localparam int RM_LOG2    = $clog2(INTERPOLATION * DIFF_DELAY);
  localparam int R_LOG2     = $clog2(INTERPOLATION);
  localparam int GAIN_SHIFT = STAGES * RM_LOG2 - R_LOG2;
  localparam int ACC_WIDTH  = INPUT_WIDTH + GAIN_SHIFT;
  localparam int PW         = R_LOG2;
  localparam int SW         = (ACC_WIDTH > OUTPUT_WIDTH) ? ACC_WIDTH : OUTPUT_WIDTH;
  localparam logic [PW-1:0] PHASE_LAST = PW'(INTERPOLATION - 1);
  localparam logic signed [SW-1:0] SAT_MAX =
    {{(SW-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN =
    {{(SW-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t                         state_q, state_d;
  logic [PW-1:0]                  phase_q, phase_d;
  logic signed [ACC_WIDTH-1:0]    integ_q [STAGES];
  logic signed [ACC_WIDTH-1:0]    integ_d [STAGES];
  logic signed [ACC_WIDTH-1:0]    dly_q   [STAGES][DIFF_DELAY];
  logic signed [ACC_WIDTH-1:0]    dly_d   [STAGES][DIFF_DELAY];
  logic signed [OUTPUT_WIDTH-1:0] data_out_q, data_out_d;
  logic                           output_valid_q, output_valid_d;

  logic                           data_ready;
  logic                           accept;
  logic                           advance;
  logic                           underflow;
  logic signed [ACC_WIDTH-1:0]    comb_in [STAGES+1];
  logic signed [ACC_WIDTH-1:0]    acc_biased;
  logic signed [ACC_WIDTH-1:0]    acc_shifted;
  logic signed [SW-1:0]           acc_wide;
  logic signed [OUTPUT_WIDTH-1:0] sat_value;

  assign data_ready = bus.out_ready && (phase_q == '0);
  assign accept     = data_ready && bus.data_valid;
  assign advance    = bus.out_ready && ((phase_q != '0) || accept);
  assign underflow  = (state_q == RUN) && (phase_q == '0) && bus.out_ready && !bus.data_valid;

  // Comb section is a purely combinational chain evaluated once per accepted sample.
  assign comb_in[0] = ACC_WIDTH'($signed(bus.data_in));
  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_comb
      assign comb_in[gi+1] = comb_in[gi] - dly_q[gi][DIFF_DELAY-1];
    end
  endgenerate

`ifdef CIC_INTERP_ROUND_EN
  localparam logic signed [ACC_WIDTH-1:0] ROUND_BIAS =
    ({{(ACC_WIDTH-1){1'b0}}, 1'b1} << GAIN_SHIFT) >> 1;
  assign acc_biased = integ_q[STAGES-1] + ROUND_BIAS;
`else
  assign acc_biased = integ_q[STAGES-1];
`endif

  assign acc_shifted = acc_biased >>> GAIN_SHIFT;
  assign acc_wide    = SW'(acc_shifted);

  always_comb begin
    sat_value = OUTPUT_WIDTH'(acc_wide);
    if (acc_wide > SAT_MAX) begin
      sat_value = OUTPUT_WIDTH'(SAT_MAX);
    end else if (acc_wide < SAT_MIN) begin
      sat_value = OUTPUT_WIDTH'(SAT_MIN);
    end
  end

  always_comb begin
    dly_d = dly_q;
    if (accept) begin
      for (int k = 0; k < STAGES; k++) begin
        dly_d[k][0] = comb_in[k];
        for (int j = 1; j < DIFF_DELAY; j++) begin
          dly_d[k][j] = dly_q[k][j-1];
        end
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    integ_d        = integ_q;
    data_out_d     = data_out_q;
    output_valid_d = 1'b0;
    if (advance) begin
      // Zero-stuffing: the comb output enters only on the phase-0 slot.
      integ_d[0] = integ_q[0] + ((phase_q == '0) ? comb_in[STAGES] : '0);
      for (int k = 1; k < STAGES; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
      phase_d        = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
      data_out_d     = sat_value;
      output_valid_d = 1'b1;
    end
    if (accept) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      phase_q        <= '0;
      data_out_q     <= '0;
      output_valid_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k] <= '0;
        for (int j = 0; j < DIFF_DELAY; j++) begin
          dly_q[k][j] <= '0;
        end
      end
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      data_out_q     <= data_out_d;
      output_valid_q <= output_valid_d;
      integ_q        <= integ_d;
      dly_q          <= dly_d;
    end
  end

  assign bus.data_ready   = data_ready;
  assign bus.data_out     = data_out_q;
  assign bus.output_valid = output_valid_q;
  assign bus.underflow    = underflow;
endmodule

// File: tb/tb_cic_interpolator.sv
// Scoreboard bench for cic_interpolator (N=3, R=8, M=1, 16-bit output):
// expected outputs come from direct FIR convolution with the boxcar^3 impulse response.
module tb_cic_interpolator;
  localparam int IW = 32;
  localparam int OW = 16;
  localparam int NTAPS = 22;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cic_interpolator_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus ();

  cic_interpolator #(
    .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .STAGES(3), .INTERPOLATION(8), .DIFF_DELAY(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int     tests = 0;
  int     fails = 0;
  longint h [NTAPS];
  longint xs [$];
  longint sb [$];
  longint last_out = 0;
  longint mon_exp;
  int     out_idx = 0;
  int     ones_cnt = 0;
  int     w;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Output on advance n is y[n-3]/64, y = h convolved with the zero-stuffed input.
  function automatic longint expected_out(input int n);
    longint y = 0;
    longint q;
    int m = n - 3;
    for (int kk = 0; kk < xs.size(); kk++) begin
      int j = m - 8 * kk;
      if (j >= 0 && j < NTAPS) y += h[j] * xs[kk];
    end
`ifdef CIC_INTERP_ROUND_EN
    y += 32;
`endif
    q = y >>> 6;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  task automatic push_sample(input longint v);
    int k;
    xs.push_back(v);
    k = xs.size() - 1;
    for (int p = 0; p < 8; p++) sb.push_back(expected_out(8 * k + p));
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_out = 0;
    end else if (bus.output_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %0d, expected no output", bus.data_out);
      end else begin
        mon_exp = sb.pop_front();
        check("data_out", longint'(bus.data_out), mon_exp);
        $display("[TB] out #%0d data_out=%0d expected=%0d", out_idx, bus.data_out, mon_exp);
      end
      if (bus.data_out == 1) ones_cnt++;
      out_idx++;
      last_out = longint'(bus.data_out);
    end else begin
      check("data_out_hold", longint'(bus.data_out), last_out);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.data_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_data_out", longint'(bus.data_out), 0);
    check("rst_output_valid", bus.output_valid, 0);
    check("rst_ready_tracks_lo", bus.data_ready, 0);
    bus.out_ready = 1'b1;
    #1;
    check("rst_ready_tracks_hi", bus.data_ready, 1);
    repeat (2) cycle();
    sb.delete();
    xs.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("idle_no_underflow", bus.underflow, 0);
      check("idle_no_output", bus.output_valid, 0);
    end
  endtask

  task automatic send(input longint v, input bit stall_p0, input bit starve,
                      input int stall_mid_at, output int waits_o);
    int waits = 0;
    if (starve) begin
      bus.data_valid = 1'b0;
      while (!bus.data_ready && waits < 50) begin cycle(); waits++; end
      for (int i = 0; i < 4; i++) begin
        check("underflow_pulse", bus.underflow, 1);
        cycle();
        check("underflow_no_valid", bus.output_valid, 0);
      end
      waits = 0;
    end
    bus.data_in = IW'(v);
    bus.data_valid = 1'b1;
    while (!bus.data_ready && waits < 50) begin cycle(); waits++; end
    waits_o = waits;
    if (waits >= 50) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got data_ready=0 after %0d cycles, expected 1", waits);
      return;
    end
    if (stall_p0) begin
      bus.out_ready = 1'b0;
      #1;
      check("p0_stall_ready", bus.data_ready, 0);
      for (int i = 0; i < 5; i++) begin
        cycle();
        check("p0_stall_no_valid", bus.output_valid, 0);
        check("p0_stall_ready_lo", bus.data_ready, 0);
      end
      bus.out_ready = 1'b1;
      #1;
    end
    push_sample(v);
    cycle();
    bus.data_valid = 1'b0;
    if (stall_mid_at >= 0) begin
      repeat (stall_mid_at) cycle();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        cycle();
        check("mid_stall_no_valid", bus.output_valid, 0);
      end
      bus.out_ready = 1'b1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin cycle(); n++; end
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic run_dc_reference();
    for (int i = 0; i < 8; i++) begin
      send(1000, 1'b0, 1'b0, -1, w);
      if (i > 0) check("ready_duty_gap", w, 7);
    end
    drain();
    check("dc_final", longint'(bus.data_out), 1000);
  endtask

  initial begin
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < 8; c++)
          h[a + b + c] += 1;
    bus.data_in = '0;
    bus.data_valid = 1'b0;
    bus.out_ready = 1'b1;
    cycle();
    apply_reset();

    // DC step
    run_dc_reference();

    // Negative DC and saturation
    apply_reset();
    for (int i = 0; i < 6; i++) send(-1000, 1'b0, 1'b0, -1, w);
    drain();
    check("neg_dc", longint'(bus.data_out), -1000);
    for (int i = 0; i < 6; i++) send(40000, 1'b0, 1'b0, -1, w);
    drain();
    check("sat_pos", longint'(bus.data_out), 32767);
    for (int i = 0; i < 6; i++) send(-40000, 1'b0, 1'b0, -1, w);
    drain();
    check("sat_neg", longint'(bus.data_out), -32768);

    // Impulse
    apply_reset();
    ones_cnt = 0;
    send(1, 1'b0, 1'b0, -1, w);
    for (int i = 0; i < 4; i++) send(0, 1'b0, 1'b0, -1, w);
    drain();
`ifdef CIC_INTERP_ROUND_EN
    check("impulse_ones", ones_cnt, 8);
`else
    check("impulse_ones", ones_cnt, 0);
`endif

    // Back-pressure at phase 3 and at phase 0
    apply_reset();
    for (int i = 0; i < 8; i++)
      send(1000, (i == 4), 1'b0, (i == 2) ? 2 : -1, w);
    drain();
    check("bp_final", longint'(bus.data_out), 1000);

    // Input starvation in RUN
    apply_reset();
    for (int i = 0; i < 8; i++) send(1000, 1'b0, (i == 3), -1, w);
    drain();
    check("starve_final", longint'(bus.data_out), 1000);

    // Reset mid-run at phase 5, then the DC reference again
    apply_reset();
    for (int i = 0; i < 3; i++) send(1000, 1'b0, 1'b0, -1, w);
    repeat (4) cycle();
    apply_reset();
    run_dc_reference();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end
endmodule
